// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: select codes, FSM states, command layout.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_LT  = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic       use_acc;
    logic       wb;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Carry/overflow are only meaningful for ADD and SUB; other ops leave them stale.
  function automatic logic sel_has_flags(input logic [2:0] sel);
    return (sel == ALU_ADD) || (sel == ALU_SUB);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered occupancy count; pushes when full and pops when empty are ignored.
module cmd_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Queues ALU commands, issues them one at a time through registered operands,
// and returns the captured result/flags over a valid/ready response stream.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_sel,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_use_acc,
  input  logic       cmd_wb,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_out,
  output logic       rsp_cf,
  output logic       rsp_of,
  output logic       rsp_zf,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_out,
  input  logic       alu_cf,
  input  logic       alu_of,
  input  logic       alu_zf,
  output logic [3:0] acc,
  output logic [7:0] op_cnt
);

  cmd_t               new_cmd;
  cmd_t               head;
  logic [CMD_W-1:0]   head_bits;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               wb_q;
  state_t             state;
  state_t             state_nxt;

  assign new_cmd   = '{sel: cmd_sel, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc, wb: cmd_wb};
  assign head      = cmd_t'(head_bits);
  assign cmd_ready = !fifo_full;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .wdata (new_cmd),
    .pop   (pop),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: state_nxt = S_RESP;
      S_RESP:    if (rsp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      wb_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      rsp_cf    <= 1'b0;
      rsp_of    <= 1'b0;
      rsp_zf    <= 1'b0;
      acc       <= '0;
      op_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            alu_sel <= head.sel;
            alu_b   <= head.b;
            alu_a   <= head.use_acc ? acc : head.a;
            wb_q    <= head.wb;
          end
        end
        S_CAPTURE: begin
          rsp_out   <= alu_out;
          rsp_zf    <= alu_zf;
          rsp_cf    <= sel_has_flags(alu_sel) && alu_cf;
          rsp_of    <= sel_has_flags(alu_sel) && alu_of;
          rsp_valid <= 1'b1;
          if (wb_q) acc <= alu_out;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (op_cnt != 8'hFF) op_cnt <= op_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver with a behavioural ALU and in-order response model.
module tb_alu_cmd_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_sel;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_use_acc;
  logic       cmd_wb;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_out;
  logic       rsp_cf;
  logic       rsp_of;
  logic       rsp_zf;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_out;
  logic       alu_cf;
  logic       alu_of;
  logic       alu_zf;
  logic [3:0] acc;
  logic [7:0] op_cnt;

  int checks   = 0;
  int failures = 0;

  logic [6:0] exp_q[$];
  logic [3:0] model_acc;
  logic [6:0] alu_r;

  always #5 clk = ~clk;

  alu_cmd_driver #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel), .cmd_a(cmd_a),
    .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_wb(cmd_wb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_cf(rsp_cf), .rsp_of(rsp_of), .rsp_zf(rsp_zf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_cf(alu_cf), .alu_of(alu_of), .alu_zf(alu_zf),
    .acc(acc), .op_cnt(op_cnt)
  );

  // Reference result {out, cf, of, zf}; cf/of are 0 for ops without carry semantics.
  function automatic logic [6:0] ref_alu(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb, res, sres;
    logic c, o;
    logic [3:0] r;
    ua = int'(a); ub = int'(b);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    c = 1'b0; o = 1'b0; res = 0; sres = 0;
    case (s)
      3'd0: begin res = ua + ub; c = (res > 15); sres = sa + sb; o = (sres > 7) || (sres < -8); end
      3'd1: begin res = ua - ub; c = (ua < ub);  sres = sa - sb; o = (sres > 7) || (sres < -8); end
      3'd2: res = 15 - ua;
      3'd3: res = ua & ub;
      3'd4: res = ua | ub;
      3'd5: res = ua ^ ub;
      3'd6: res = (ua < ub) ? 1 : 0;
      default: res = (ua == ub) ? 1 : 0;
    endcase
    r = 4'((res + 16) % 16);
    return {r, c, o, (r == 4'd0)};
  endfunction

  // Stand-in ALU: non-ADD/SUB ops present stale-looking flags of 1 to expose missing masking.
  always_comb begin
    alu_r   = ref_alu(alu_sel, alu_a, alu_b);
    alu_out = alu_r[6:3];
    alu_zf  = alu_r[0];
    if (alu_sel == 3'd0 || alu_sel == 3'd1) begin
      alu_cf = alu_r[2];
      alu_of = alu_r[1];
    end else begin
      alu_cf = 1'b1;
      alu_of = 1'b1;
    end
  end

  task automatic model_push(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                            input logic ua, input logic wb);
    logic [6:0] e;
    e = ref_alu(s, ua ? model_acc : a, b);
    exp_q.push_back(e);
    if (wb) model_acc = e[6:3];
  endtask

  task automatic push_cmd(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                          input logic ua, input logic wb);
    bit ok;
    cmd_valid = 1'b1; cmd_sel = s; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_wb = wb;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      $display("FAIL push_timeout cmd_ready stayed 0 for 50 cycles");
      $fatal(1, "push timeout");
    end
    model_push(s, a, b, ua, wb);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_acc = 4'd0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    got = {cmd_ready, rsp_valid, rsp_out, rsp_cf, rsp_of, rsp_zf, alu_a, alu_b, alu_sel, acc, op_cnt};
    checks++;
    if (got !== 32'h8000_0000) begin
      failures++;
      $display("FAIL reset_state got=%h expected=%h", got, 32'h8000_0000);
    end
    rst = 1'b0;
    exp_q.delete();
    model_acc = 4'd0;
  endtask

  task automatic test_add_and_masking();
    int cyc;
    logic [6:0] e;
    do_reset();
    rsp_ready = 1'b1;
    push_cmd(3'd0, 4'd7, 4'd1, 1'b0, 1'b0);
    wait_rsp(cyc);
    checks++;
    if (cyc !== 2) begin failures++; $display("FAIL add_latency got=%0d expected=2", cyc); end
    e = exp_q.pop_front();
    checks++;
    if ({rsp_out, rsp_cf, rsp_of, rsp_zf} !== {4'd8, 1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL add_overflow got=%b expected=%b", {rsp_out, rsp_cf, rsp_of, rsp_zf}, {4'd8, 3'b010});
    end
    push_cmd(3'd3, 4'hC, 4'h3, 1'b0, 1'b0);
    wait_rsp(cyc);
    e = exp_q.pop_front();
    checks++;
    if ({rsp_out, rsp_cf, rsp_of, rsp_zf} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL and_mask got=%b expected=%b", {rsp_out, rsp_cf, rsp_of, rsp_zf}, 7'b0000001);
    end
    push_cmd(3'd7, 4'd5, 4'd5, 1'b0, 1'b0);
    wait_rsp(cyc);
    e = exp_q.pop_front();
    checks++;
    if ({rsp_out, rsp_cf, rsp_of, rsp_zf} !== {4'd1, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL eq_result got=%b expected=%b", {rsp_out, rsp_cf, rsp_of, rsp_zf}, 7'b0001000);
    end
    push_cmd(3'd1, 4'd2, 4'd5, 1'b0, 1'b0);
    wait_rsp(cyc);
    e = exp_q.pop_front();
    checks++;
    if ({rsp_out, rsp_cf, rsp_of, rsp_zf} !== e) begin
      failures++; $display("FAIL sub_borrow got=%b expected=%b", {rsp_out, rsp_cf, rsp_of, rsp_zf}, e);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({alu_sel, alu_a, alu_b} !== {3'd1, 4'd2, 4'd5}) begin
      failures++; $display("FAIL alu_hold got=%h expected=%h", {alu_sel, alu_a, alu_b}, {3'd1, 4'd2, 4'd5});
    end
  endtask

  task automatic test_acc_chain();
    int cyc;
    logic [6:0] e;
    logic [3:0] bs [4];
    logic [3:0] outs [4];
    bs   = '{4'd3, 4'd3, 4'd3, 4'd8};
    outs = '{4'd3, 4'd6, 4'd9, 4'd1};
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_cmd(3'd0, 4'($urandom_range(0, 15)), bs[i], 1'b1, 1'b1);
      wait_rsp(cyc);
      e = exp_q.pop_front();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_out !== outs[i] || {rsp_out, rsp_cf, rsp_of, rsp_zf} !== e) begin
        failures++; $display("FAIL chain_step%0d got=%b expected_out=%h model=%b", i, {rsp_out, rsp_cf, rsp_of, rsp_zf}, outs[i], e);
      end
    end
    checks++;
    if (rsp_cf !== 1'b1) begin failures++; $display("FAIL chain_carry got=%b expected=1", rsp_cf); end
    @(negedge clk);
    checks++;
    if ({acc, op_cnt} !== {4'd1, 8'd4}) begin
      failures++; $display("FAIL chain_final acc=%h op_cnt=%0d expected acc=1 op_cnt=4", acc, op_cnt);
    end
  endtask

  task automatic test_backpressure();
    int accepted;
    logic [6:0] held, e;
    logic [2:0] s;
    logic [3:0] a, b;
    logic ua, wb;
    do_reset();
    rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 12 && accepted < 6; i++) begin
      s = 3'($urandom_range(0, 7)); a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
      ua = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 1));
      cmd_valid = 1'b1; cmd_sel = s; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_wb = wb;
      if (cmd_ready) begin
        model_push(s, a, b, ua, wb);
        accepted++;
      end
      @(negedge clk);
    end
    checks++;
    if (accepted !== 5 || cmd_ready !== 1'b0) begin
      failures++; $display("FAIL full_accept accepted=%0d cmd_ready=%b expected 5 and 0", accepted, cmd_ready);
    end
    cmd_valid = 1'b0;
    held = {rsp_out, rsp_cf, rsp_of, rsp_zf};
    checks++;
    if (rsp_valid !== 1'b1 || held !== exp_q[0]) begin
      failures++; $display("FAIL bp_first valid=%b got=%b expected=%b", rsp_valid, held, exp_q[0]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || {rsp_out, rsp_cf, rsp_of, rsp_zf} !== held) begin
      failures++; $display("FAIL bp_hold valid=%b got=%b expected=%b", rsp_valid, {rsp_out, rsp_cf, rsp_of, rsp_zf}, held);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      if (rsp_valid) begin
        e = exp_q.pop_front();
        checks++;
        if ({rsp_out, rsp_cf, rsp_of, rsp_zf} !== e) begin
          failures++; $display("FAIL bp_drain got=%b expected=%b", {rsp_out, rsp_cf, rsp_of, rsp_zf}, e);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL bp_missing got=%0d left expected=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    bit seen;
    logic [31:0] got;
    do_reset();
    rsp_ready = 1'b0;
    push_cmd(3'd0, 4'd5, 4'd2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      push_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)), 1'b0, 1'b1);
    wait_rsp(cyc);
    checks++;
    if (rsp_valid !== 1'b1 || acc !== 4'd7) begin
      failures++; $display("FAIL pre_reset valid=%b acc=%h expected 1 and 7", rsp_valid, acc);
    end
    rst = 1'b1;
    @(negedge clk);
    got = {cmd_ready, rsp_valid, rsp_out, rsp_cf, rsp_of, rsp_zf, alu_a, alu_b, alu_sel, acc, op_cnt};
    checks++;
    if (got !== 32'h8000_0000) begin
      failures++; $display("FAIL mid_reset got=%h expected=%h", got, 32'h8000_0000);
    end
    rst = 1'b0;
    exp_q.delete();
    model_acc = 4'd0;
    rsp_ready = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || acc !== 4'd0) begin
      failures++; $display("FAIL post_reset rsp_seen=%b acc=%h expected 0 and 0", seen, acc);
    end
  endtask

  task automatic test_saturation();
    int cyc;
    logic [6:0] e;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      push_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_rsp(cyc);
      e = exp_q.pop_front();
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_out, rsp_cf, rsp_of, rsp_zf} !== e) begin
        failures++; $display("FAIL rand_op%0d valid=%b got=%b expected=%b", i, rsp_valid, {rsp_out, rsp_cf, rsp_of, rsp_zf}, e);
      end
    end
    @(negedge clk);
    checks++;
    if (op_cnt !== 8'd255) begin failures++; $display("FAIL op_cnt_sat got=%0d expected=255", op_cnt); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_sel = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; cmd_wb = 1'b0; rsp_ready = 1'b0; model_acc = 4'd0;
    test_reset();
    test_add_and_masking();
    test_acc_chain();
    test_backpressure();
    test_reset_mid_op();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
